uart_rx_fifo_param: RTL and testbench

//  Next-generation UART receiver: configurable frame format, 2-flop rx synchroniser, false-start rejection.

---
 rtl/uart_rx_pkg.sv | 24 ++
 rtl/uart_rx_fifo_param_if.sv | 30 +++
 rtl/uart_rx_sync_fifo.sv | 80 ++++++++
 rtl/uart_rx_fifo_param.sv | 263 ++++++++++++++++++++++++++
 tb/tb_uart_rx_fifo_param.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the uart_rx_fifo_param receiver.
// The package holds the FSM state encoding, the minimum bit period and the parity helper.
package uart_rx_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE   = 3'd0;
  localparam state_t START  = 3'd1;
  localparam state_t DATA   = 3'd2;
  localparam state_t PARITY = 3'd3;
  localparam state_t STOP   = 3'd4;
  localparam state_t STOP2  = 3'd5;
  localparam state_t PUSH   = 3'd6;
  localparam state_t FERR   = 3'd7;

  // Shortest usable bit period; smaller clk_div values are clamped to this.
  localparam logic [31:0] MIN_CLK_DIV = 32'd2;

  // Expected parity bit for up to 9 data bits (zero-extended); odd=1 selects odd parity.
  function automatic logic calc_parity(input logic [8:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_param_if.sv
// Bus-side interface of the UART receiver: FIFO drain, status flags and interrupt.
// master = register/bus block, slave = receiver.
interface uart_rx_fifo_param_if #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              empty;
  logic              full;
  logic [LVL_W-1:0]  fifo_level;
  logic              err_clr;
  logic              frame_err;
  logic              overrun_err;
  logic              parity_err;
  logic              busy;
  logic              irq;

  modport master (
    output rd_en, err_clr,
    input  rd_data, empty, full, fifo_level, frame_err, overrun_err, parity_err, busy, irq
  );

  modport slave (
    input  rd_en, err_clr,
    output rd_data, empty, full, fifo_level, frame_err, overrun_err, parity_err, busy, irq
  );
endinterface

// File: rtl/uart_rx_sync_fifo.sv
// Synchronous receive FIFO with a registered head word.
// Pointers carry one extra wrap bit so level = wr_ptr - rd_ptr distinguishes full from empty.
// A write while full is accepted only when a read happens in the same cycle.
module uart_rx_sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty,
  output logic              full,
  output logic [LW-1:0]     level
);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [LW-1:0]     wr_ptr_r;
  logic [LW-1:0]     rd_ptr_r;
  logic [DATA_W-1:0] rd_data_r;
  logic [LW-1:0]     level_s;
  logic [LW-1:0]     rd_ptr_inc_s;
  logic              do_rd_s;
  logic              do_wr_s;

  // Occupancy and qualified read/write strobes.
  always_comb begin
    level_s      = wr_ptr_r - rd_ptr_r;
    rd_ptr_inc_s = rd_ptr_r + {{(LW-1){1'b0}}, 1'b1};
    do_rd_s      = rd_en && (level_s != {LW{1'b0}});
    do_wr_s      = wr_en && ((level_s != LW'(DEPTH)) || do_rd_s);
  end

  // Read and write pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {LW{1'b0}};
      rd_ptr_r <= {LW{1'b0}};
    end else begin
      if (do_wr_s) begin
        wr_ptr_r <= wr_ptr_r + {{(LW-1){1'b0}}, 1'b1};
      end
      if (do_rd_s) begin
        rd_ptr_r <= rd_ptr_inc_s;
      end
    end
  end

  // Storage array; contents are discarded logically by the pointer reset.
  always_ff @(posedge clk) begin
    if (do_wr_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
    end
  end

  // Registered head: next entry after a pop (bypassing a same-cycle write), or the first write into empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_r <= {DATA_W{1'b0}};
    end else if (do_rd_s) begin
      if (do_wr_s && (wr_ptr_r[AW-1:0] == rd_ptr_inc_s[AW-1:0])) begin
        rd_data_r <= wr_data;
      end else begin
        rd_data_r <= mem_r[rd_ptr_inc_s[AW-1:0]];
      end
    end else if (do_wr_s && (level_s == {LW{1'b0}})) begin
      rd_data_r <= wr_data;
    end
  end

  assign rd_data = rd_data_r;
  assign level   = level_s;
  assign empty   = (level_s == {LW{1'b0}});
  assign full    = (level_s == LW'(DEPTH));

endmodule

// File: rtl/uart_rx_fifo_param.sv
// UART receiver with 2-flop rx synchroniser, false-start rejection, receive FIFO,
// sticky error flags and a registered level/error interrupt.
// Optional feature macro: UART_RX_PARITY_EN adds parity_en/parity_odd inputs and a parity bit
// after the data; without it parity_err is constant 0.
module uart_rx_fifo_param
  import uart_rx_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int IRQ_THRESH = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] clk_div,
  input  logic        stop2,
  input  logic        rx,
`ifdef UART_RX_PARITY_EN
  input  logic        parity_en,
  input  logic        parity_odd,
`endif
  uart_rx_fifo_param_if.slave bus
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int BIT_W = $clog2(DATA_W + 1);

  logic              rx_meta_r;
  logic              rx_sync_r;
  state_t            state_r;
  state_t            state_next_s;
  logic [31:0]       cnt_r;
  logic [BIT_W-1:0]  bit_cnt_r;
  logic [DATA_W-1:0] shift_r;
  logic [31:0]       div_r;
  logic              stop2_r;
  logic              par_on_r;
  logic              par_odd_r;
  logic              parity_bad_r;
  logic              frame_err_r;
  logic              overrun_err_r;
  logic              parity_err_r;
  logic              busy_r;
  logic              irq_r;

  logic [31:0]       div_sel_s;
  logic              par_on_s;
  logic              par_odd_s;
  logic              start_det_s;
  logic              half_tick_s;
  logic              bit_tick_s;
  logic              last_bit_s;
  logic              push_s;
  logic              ferr_set_s;
  logic              par_mis_s;
  logic              ovr_set_s;
  logic              fifo_wr_s;
  logic              fifo_empty_s;
  logic              fifo_full_s;
  logic [LVL_W-1:0]  fifo_level_s;
  logic [DATA_W-1:0] fifo_rd_data_s;

  // Run-time parity configuration source.
  always_comb begin
`ifdef UART_RX_PARITY_EN
    par_on_s  = parity_en;
    par_odd_s = parity_odd;
`else
    par_on_s  = 1'b0;
    par_odd_s = 1'b0;
`endif
  end

  // Bit timing: clamp the divider, detect the half-bit and full-bit points.
  always_comb begin
    div_sel_s   = (clk_div < MIN_CLK_DIV) ? MIN_CLK_DIV : clk_div;
    start_det_s = (state_r == IDLE) && !rx_sync_r;
    half_tick_s = (cnt_r == ((div_r >> 1) - 32'd1));
    bit_tick_s  = (cnt_r == (div_r - 32'd1));
    last_bit_s  = (bit_cnt_r == BIT_W'(DATA_W - 1));
  end

  // Two-flop synchroniser on the asynchronous line, preset to idle-high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (!rx_sync_r) state_next_s = START;
        else            state_next_s = IDLE;
      end
      START: begin
        if (half_tick_s) state_next_s = rx_sync_r ? IDLE : DATA;
        else             state_next_s = START;
      end
      DATA: begin
        if (bit_tick_s && last_bit_s) state_next_s = par_on_r ? PARITY : STOP;
        else                          state_next_s = DATA;
      end
      PARITY: begin
        if (bit_tick_s) state_next_s = STOP;
        else            state_next_s = PARITY;
      end
      STOP: begin
        if (bit_tick_s) state_next_s = rx_sync_r ? (stop2_r ? STOP2 : PUSH) : FERR;
        else            state_next_s = STOP;
      end
      STOP2: begin
        if (bit_tick_s) state_next_s = rx_sync_r ? PUSH : FERR;
        else            state_next_s = STOP2;
      end
      PUSH: begin
        state_next_s = IDLE;
      end
      FERR: begin
        if (rx_sync_r) state_next_s = IDLE;
        else           state_next_s = FERR;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // FSM outputs: push, error-set strobes and the FIFO write qualification.
  always_comb begin
    push_s     = (state_r == PUSH) && !parity_bad_r;
    ferr_set_s = ((state_r == STOP) || (state_r == STOP2)) && bit_tick_s && !rx_sync_r;
    par_mis_s  = (state_r == PARITY) && bit_tick_s &&
                 (rx_sync_r != calc_parity(9'(shift_r), par_odd_r));
    ovr_set_s  = push_s && fifo_full_s && !bus.rd_en;
    fifo_wr_s  = push_s && !ovr_set_s;
  end

  // Datapath: bit counter, data shifter and per-frame configuration latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r        <= 32'd0;
      bit_cnt_r    <= {BIT_W{1'b0}};
      shift_r      <= {DATA_W{1'b0}};
      div_r        <= MIN_CLK_DIV;
      stop2_r      <= 1'b0;
      par_on_r     <= 1'b0;
      par_odd_r    <= 1'b0;
      parity_bad_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          cnt_r        <= 32'd0;
          bit_cnt_r    <= {BIT_W{1'b0}};
          parity_bad_r <= 1'b0;
          if (start_det_s) begin
            div_r     <= div_sel_s;
            stop2_r   <= stop2;
            par_on_r  <= par_on_s;
            par_odd_r <= par_odd_s;
          end
        end
        START: begin
          cnt_r <= half_tick_s ? 32'd0 : cnt_r + 32'd1;
        end
        DATA: begin
          if (bit_tick_s) begin
            cnt_r     <= 32'd0;
            shift_r   <= {rx_sync_r, shift_r[DATA_W-1:1]};
            bit_cnt_r <= bit_cnt_r + {{(BIT_W-1){1'b0}}, 1'b1};
          end else begin
            cnt_r <= cnt_r + 32'd1;
          end
        end
        PARITY: begin
          if (bit_tick_s) begin
            cnt_r        <= 32'd0;
            parity_bad_r <= par_mis_s;
          end else begin
            cnt_r <= cnt_r + 32'd1;
          end
        end
        STOP, STOP2: begin
          cnt_r <= bit_tick_s ? 32'd0 : cnt_r + 32'd1;
        end
        default: begin
          cnt_r <= 32'd0;
        end
      endcase
    end
  end

  // Sticky error flags: a new error in the clearing cycle wins over err_clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err_r   <= 1'b0;
      overrun_err_r <= 1'b0;
      parity_err_r  <= 1'b0;
    end else begin
      if (ferr_set_s)       frame_err_r <= 1'b1;
      else if (bus.err_clr) frame_err_r <= 1'b0;
      if (ovr_set_s)        overrun_err_r <= 1'b1;
      else if (bus.err_clr) overrun_err_r <= 1'b0;
`ifdef UART_RX_PARITY_EN
      if (par_mis_s)        parity_err_r <= 1'b1;
      else if (bus.err_clr) parity_err_r <= 1'b0;
`else
      parity_err_r <= 1'b0;
`endif
    end
  end

  // Registered busy and interrupt outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r <= 1'b0;
      irq_r  <= 1'b0;
    end else begin
      busy_r <= (state_next_s != IDLE);
      irq_r  <= (fifo_level_s >= LVL_W'(IRQ_THRESH)) || frame_err_r || overrun_err_r || parity_err_r;
    end
  end

  uart_rx_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (fifo_wr_s),
    .wr_data (shift_r),
    .rd_en   (bus.rd_en),
    .rd_data (fifo_rd_data_s),
    .empty   (fifo_empty_s),
    .full    (fifo_full_s),
    .level   (fifo_level_s)
  );

  assign bus.rd_data     = fifo_rd_data_s;
  assign bus.empty       = fifo_empty_s;
  assign bus.full        = fifo_full_s;
  assign bus.fifo_level  = fifo_level_s;
  assign bus.frame_err   = frame_err_r;
  assign bus.overrun_err = overrun_err_r;
  assign bus.parity_err  = parity_err_r;
  assign bus.busy        = busy_r;
  assign bus.irq         = irq_r;

endmodule

// File: tb/tb_uart_rx_fifo_param.sv
// Directed bench for uart_rx_fifo_param: nominal frame, false start, framing error,
// FIFO overrun, pop-in-push-cycle on a full FIFO and (with UART_RX_PARITY_EN) parity.
module tb_uart_rx_fifo_param;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int DIV    = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] clk_div;
  logic        stop2;
  logic        rx;
`ifdef UART_RX_PARITY_EN
  logic        parity_en;
  logic        parity_odd;
`endif

  int errors = 0;
  int checks = 0;

  uart_rx_fifo_param_if #(.DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) bus_if ();

  uart_rx_fifo_param #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (DEPTH),
    .IRQ_THRESH (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clk_div    (clk_div),
    .stop2      (stop2),
    .rx         (rx),
`ifdef UART_RX_PARITY_EN
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
`endif
    .bus        (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one frame: start, 8 data bits LSB first, optional parity, then stop level for stop_len clocks.
  // With pop_at_push, rd_en is raised for exactly the clock in which the receiver pushes.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit, input logic has_par,
                            input logic par_bit, input logic pop_at_push, input int stop_len);
    logic bits [0:10];
    int   nd;
    int   push_n;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = data[i];
    nd = 9;
    if (has_par) begin
      bits[9] = par_bit;
      nd = 10;
    end
    push_n = 3 + DIV/2 + DIV*(DATA_W + 1) + (has_par ? DIV : 0);
    for (int n = 0; n < nd*DIV + stop_len; n++) begin
      @(negedge clk);
      rx = (n < nd*DIV) ? bits[n/DIV] : stop_bit;
      bus_if.rd_en = (pop_at_push && (n == push_n));
    end
    @(negedge clk);
    bus_if.rd_en = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    @(negedge clk);
    check_eq(tag, 32'(bus_if.rd_data), 32'(exp));
    bus_if.rd_en = 1'b1;
    @(negedge clk);
    bus_if.rd_en = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    bus_if.err_clr = 1'b1;
    @(negedge clk);
    bus_if.err_clr = 1'b0;
  endtask

  initial begin
    logic [7:0] b;
    rx = 1'b1;
    clk_div = 32'(DIV);
    stop2 = 1'b0;
    bus_if.rd_en = 1'b0;
    bus_if.err_clr = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_en = 1'b0;
    parity_odd = 1'b0;
`endif
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check_eq("rst_empty", 32'(bus_if.empty), 32'd1);
    check_eq("rst_full", 32'(bus_if.full), 32'd0);
    check_eq("rst_level", 32'(bus_if.fifo_level), 32'd0);
    check_eq("rst_rd_data", 32'(bus_if.rd_data), 32'd0);
    check_eq("rst_busy", 32'(bus_if.busy), 32'd0);
    check_eq("rst_irq", 32'(bus_if.irq), 32'd0);
    check_eq("rst_ferr", 32'(bus_if.frame_err), 32'd0);
    check_eq("rst_ovr", 32'(bus_if.overrun_err), 32'd0);
    check_eq("rst_perr", 32'(bus_if.parity_err), 32'd0);

    // Nominal 8N1 frame 0xA5
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, DIV);
    check_eq("a5_level", 32'(bus_if.fifo_level), 32'd1);
    check_eq("a5_data", 32'(bus_if.rd_data), 32'hA5);
    check_eq("a5_irq", 32'(bus_if.irq), 32'd1);
    check_eq("a5_ferr", 32'(bus_if.frame_err), 32'd0);
    check_eq("a5_ovr", 32'(bus_if.overrun_err), 32'd0);
    check_eq("a5_busy", 32'(bus_if.busy), 32'd0);
    pop_check("a5_pop", 8'hA5);
    @(negedge clk);
    check_eq("a5_empty", 32'(bus_if.empty), 32'd1);
    check_eq("a5_irq_low", 32'(bus_if.irq), 32'd0);

    // False start: 4-clock low pulse
    @(negedge clk);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("fs_busy_hi", 32'(bus_if.busy), 32'd1);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    check_eq("fs_busy_lo", 32'(bus_if.busy), 32'd0);
    check_eq("fs_level", 32'(bus_if.fifo_level), 32'd0);
    check_eq("fs_ferr", 32'(bus_if.frame_err), 32'd0);

    // Framing error: 0x3C with stop held low for 40 clocks
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 40);
    check_eq("fe_ferr", 32'(bus_if.frame_err), 32'd1);
    check_eq("fe_busy", 32'(bus_if.busy), 32'd1);
    check_eq("fe_level", 32'(bus_if.fifo_level), 32'd0);
    check_eq("fe_irq", 32'(bus_if.irq), 32'd1);
    rx = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("fe_idle", 32'(bus_if.busy), 32'd0);
    check_eq("fe_level2", 32'(bus_if.fifo_level), 32'd0);
    pulse_clr();
    check_eq("fe_clr", 32'(bus_if.frame_err), 32'd0);
    @(negedge clk);
    check_eq("fe_irq_low", 32'(bus_if.irq), 32'd0);

    // 17 frames into a 16-deep FIFO without reads
    for (int i = 0; i < 17; i++) begin
      b = 8'(16 + i);
      send_frame(b, 1'b1, 1'b0, 1'b0, 1'b0, DIV);
    end
    check_eq("ov_level", 32'(bus_if.fifo_level), 32'd16);
    check_eq("ov_full", 32'(bus_if.full), 32'd1);
    check_eq("ov_flag", 32'(bus_if.overrun_err), 32'd1);
    check_eq("ov_head", 32'(bus_if.rd_data), 32'h10);
    pulse_clr();
    check_eq("ov_clr", 32'(bus_if.overrun_err), 32'd0);

    // Full FIFO, pop in the push cycle: no overrun, level stays 16
    send_frame(8'h55, 1'b1, 1'b0, 1'b0, 1'b1, DIV);
    check_eq("pp_level", 32'(bus_if.fifo_level), 32'd16);
    check_eq("pp_full", 32'(bus_if.full), 32'd1);
    check_eq("pp_ovr", 32'(bus_if.overrun_err), 32'd0);
    for (int i = 1; i < 16; i++) begin
      b = 8'(16 + i);
      pop_check("pp_order", b);
    end
    pop_check("pp_last", 8'h55);
    @(negedge clk);
    check_eq("pp_empty", 32'(bus_if.empty), 32'd1);
    check_eq("pp_level0", 32'(bus_if.fifo_level), 32'd0);

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x07 has three ones, so the correct parity bit is 1
    parity_en = 1'b1;
    parity_odd = 1'b0;
    send_frame(8'h07, 1'b1, 1'b1, 1'b0, 1'b0, DIV);
    check_eq("par_bad_flag", 32'(bus_if.parity_err), 32'd1);
    check_eq("par_bad_level", 32'(bus_if.fifo_level), 32'd0);
    check_eq("par_bad_irq", 32'(bus_if.irq), 32'd1);
    pulse_clr();
    check_eq("par_clr", 32'(bus_if.parity_err), 32'd0);
    send_frame(8'h07, 1'b1, 1'b1, 1'b1, 1'b0, DIV);
    check_eq("par_ok_flag", 32'(bus_if.parity_err), 32'd0);
    check_eq("par_ok_level", 32'(bus_if.fifo_level), 32'd1);
    check_eq("par_ok_data", 32'(bus_if.rd_data), 32'h07);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
